keyboard_matrix: RTL

KEYBOARD_MATRIX -- requirements
Module: keyboard_matrix

---
 rtl/keyboard_matrix.sv | 138 +++++++++++++
 1 files changed

// File: rtl/keyboard_matrix.sv
// Keyboard matrix emulator: queues key events, applies each one and holds it for HOLD_TICKS 1 MHz ticks.
// Optional macro KEYBOARD_MATRIX_FIFO_EN selects a 4-entry event FIFO instead of a single holding register.
module keyboard_matrix #(
    parameter int HOLD_TICKS = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1mhz_ph1_en,
    input  logic       i_key_valid,
    input  logic [5:0] i_key_code,
    input  logic       i_key_down,
    output logic       o_key_ready,
    input  logic       i_clear,
    input  logic [7:0] i_pa,
    output logic [7:0] o_pb,
    output logic       o_busy
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state, state_next;
    logic [15:0] hold_cnt, hold_cnt_next;
    logic [63:0] keys, keys_next;

    logic       full, empty, push, pop;
    logic [6:0] head;

    assign o_key_ready = !full && !i_clear;
    assign push        = i_key_valid && o_key_ready;
    assign pop         = (state == IDLE) && !empty && !i_clear;
    assign o_busy      = (state == HOLD) || !empty;

`ifdef KEYBOARD_MATRIX_FIFO_EN
    logic [6:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;

    assign full  = (count == 3'd4);
    assign empty = (count == 3'd0);
    assign head  = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {i_key_down, i_key_code};
        end
    end

    // A simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end
`else
    logic       held;
    logic [6:0] slot;

    assign full  = held;
    assign empty = !held;
    assign head  = slot;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            held <= 1'b0;
            slot <= '0;
        end else if (push) begin
            held <= 1'b1;
            slot <= {i_key_down, i_key_code};
        end else if (pop) begin
            held <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            keys     <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
            keys     <= keys_next;
        end
    end

    // Clear wins over applying the head event on the same edge.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        keys_next     = keys;
        if (i_clear) begin
            state_next    = IDLE;
            hold_cnt_next = '0;
            keys_next     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        keys_next[head[5:0]] = head[6];
                        hold_cnt_next        = 16'(HOLD_TICKS);
                        state_next           = HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == 16'd0) begin
                        state_next = IDLE;
                    end else if (clk_1mhz_ph1_en) begin
                        hold_cnt_next = hold_cnt - 16'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        o_pb = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                if (!i_pa[c] && keys[c*8+r]) begin
                    o_pb[r] = 1'b0;
                end
            end
        end
    end

endmodule
